// File: rtl/group_pkg.sv
// Shared helpers for the adder tree: clog2, saturation bounds and pairwise add functions.
// Operands are passed sign-extended to 64 bits; callers truncate the result to their width.
package group_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic longint sat_max(input int unsigned width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int unsigned width);
    return -(64'sd1 <<< (width - 1));
  endfunction

  function automatic longint add_wrap(input longint a, input longint b);
    return a + b;
  endfunction

  function automatic longint add_sat(input longint a, input longint b, input int unsigned width);
    longint s;
    s = a + b;
    if (s > sat_max(width)) return sat_max(width);
    if (s < sat_min(width)) return sat_min(width);
    return s;
  endfunction

endpackage

// File: rtl/group_add_stage.sv
// One registered level of the adder tree: N operands in, N/2 pairwise sums out.
// Saturating pairwise adds when GROUP_ADD_TREE_SAT_EN is defined, wrapping adds otherwise.
module group_add_stage
  import group_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter int unsigned NUM_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic [N*NUM_WIDTH-1:0]         in_data,
  input  logic                           in_val,
  output logic [(N/2)*NUM_WIDTH-1:0]     out_data,
  output logic                           out_val
);

  localparam int unsigned M = N / 2;

  function automatic longint pair_add(input longint a, input longint b);
`ifdef GROUP_ADD_TREE_SAT_EN
    return add_sat(a, b, NUM_WIDTH);
`else
    return add_wrap(a, b);
`endif
  endfunction

  logic [M*NUM_WIDTH-1:0] sum;

  always_comb begin
    sum = '0;
    for (int i = 0; i < int'(M); i++) begin
      sum[i*NUM_WIDTH +: NUM_WIDTH] = NUM_WIDTH'(pair_add(
          longint'(signed'(in_data[(2*i)*NUM_WIDTH +: NUM_WIDTH])),
          longint'(signed'(in_data[(2*i+1)*NUM_WIDTH +: NUM_WIDTH]))));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_val  <= 1'b0;
    end else if (en) begin
      out_data <= sum;
      out_val  <= in_val;
    end
  end

endmodule

// File: rtl/group_add_tree.sv
// Pipelined signed adder tree: input register plus log2(GROUP_NB) registered adder levels.
// Define GROUP_ADD_TREE_SAT_EN for saturating pairwise additions.
module group_add_tree
  import group_pkg::*;
#(
  parameter int unsigned GROUP_NB  = 4,
  parameter int unsigned NUM_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_WIDTH*GROUP_NB-1:0] up_data,
  input  logic                          up_val,
  output logic                          up_rdy,
  output logic [NUM_WIDTH-1:0]          dn_data,
  output logic                          dn_val,
  input  logic                          dn_rdy
);

  localparam int unsigned S = clog2(GROUP_NB);

  if (GROUP_NB < 2 || GROUP_NB > 64 || (GROUP_NB & (GROUP_NB - 1)) != 0) begin : g_bad_nb
    $fatal(1, "group_add_tree: GROUP_NB=%0d must be a power of two in 2..64", GROUP_NB);
  end
  if (NUM_WIDTH < 2 || NUM_WIDTH > 62) begin : g_bad_width
    $fatal(1, "group_add_tree: NUM_WIDTH=%0d must be in 2..62", NUM_WIDTH);
  end

  // Single global enable: every level advances or holds together.
  logic en;
  assign en     = !dn_val || dn_rdy;
  assign up_rdy = en;

  for (genvar l = 0; l <= int'(S); l++) begin : g_lvl
    localparam int unsigned N = GROUP_NB >> l;
    logic [N*NUM_WIDTH-1:0] data;
    logic                   val;

    if (l == 0) begin : g_in
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data <= '0;
          val  <= 1'b0;
        end else if (en) begin
          data <= up_data;
          val  <= up_val;
        end
      end
    end else begin : g_add
      group_add_stage #(
        .N         (GROUP_NB >> (l - 1)),
        .NUM_WIDTH (NUM_WIDTH)
      ) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .in_data  (g_lvl[l-1].data),
        .in_val   (g_lvl[l-1].val),
        .out_data (data),
        .out_val  (val)
      );
    end
  end

  assign dn_data = g_lvl[S].data;
  assign dn_val  = g_lvl[S].val;

endmodule
